// File: rtl/image_pkg.sv
// Shared image geometry for the frame loader and the 2x2 block-average downscaler.
// Holds frame dimensions, loader FSM encoding and the raster pixel index helper.
package image_pkg;

    localparam int LARGURA      = 8;
    localparam int ALTURA       = 8;
    localparam int PIX_W        = 8;
    localparam int NOVA_LARGURA = LARGURA / 2;
    localparam int NOVA_ALTURA  = ALTURA / 2;
    localparam int FRAME_W      = LARGURA * ALTURA * PIX_W;
    localparam int COL_W        = $clog2(LARGURA);
    localparam int ROW_W        = $clog2(ALTURA);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } load_state_t;

    // Byte 0 of the flat frame is (row 0, col 0), matching the downscaler's indexing.
    function automatic int pixel_index(input int linha, input int coluna);
        return linha * LARGURA + coluna;
    endfunction

endpackage

// File: rtl/pixel_frame_loader_if.sv
// Pixel stream in / assembled frame out bundle between the source, loader and downscaler.
// The loader takes the slave side; a pixel source plus frame consumer takes the master side.
interface pixel_frame_loader_if;
    import image_pkg::*;

    logic [PIX_W-1:0]   pix_data;
    logic               pix_valid;
    logic               pix_sof;
    logic               pix_ready;
    logic [FRAME_W-1:0] frame_out;
    logic               frame_valid;
    logic               frame_ack;
    logic               sof_error;

    modport master (
        output pix_data, pix_valid, pix_sof, frame_ack,
        input  pix_ready, frame_out, frame_valid, sof_error
    );

    modport slave (
        input  pix_data, pix_valid, pix_sof, frame_ack,
        output pix_ready, frame_out, frame_valid, sof_error
    );

endinterface

// File: rtl/pixel_frame_loader.sv
// Assembles one raster frame from a valid/ready pixel stream and holds it stable
// for the downscaler until frame_ack; sof mid-frame restarts the frame and pulses sof_error.
module pixel_frame_loader
    import image_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    pixel_frame_loader_if.slave pix
);

    load_state_t      state, next_state;
    logic [COL_W-1:0] coluna;
    logic [ROW_W-1:0] linha;
    logic             beat;
    logic             last_pixel;

    assign beat       = pix.pix_valid & pix.pix_ready;
    assign last_pixel = (linha == ROW_W'(ALTURA - 1)) && (coluna == COL_W'(LARGURA - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets its default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (beat && pix.pix_sof)                    next_state = LOAD;
            LOAD:    if (beat && !pix.pix_sof && last_pixel)     next_state = FULL;
            FULL:    if (pix.frame_ack)                          next_state = IDLE;
            default:                                             next_state = IDLE;
        endcase
    end

    // NOTE: frame_out is a wide register (not a RAM) and must read as zero out of reset, so it is reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            linha           <= '0;
            coluna          <= '0;
            pix.frame_out   <= '0;
            pix.frame_valid <= 1'b0;
            pix.pix_ready   <= 1'b0;
            pix.sof_error   <= 1'b0;
        end else begin
            pix.pix_ready   <= (next_state != FULL);
            pix.frame_valid <= (next_state == FULL);
            pix.sof_error   <= beat && pix.pix_sof && (state == LOAD);

            if (beat && state != FULL) begin
                if (pix.pix_sof) begin
                    // sof always (re)starts at pixel 0, whether from IDLE or mid-frame.
                    pix.frame_out[0 +: PIX_W] <= pix.pix_data;
                    linha  <= '0;
                    coluna <= COL_W'(1);
                end else if (state == LOAD) begin
                    pix.frame_out[pixel_index(int'(linha), int'(coluna)) * PIX_W +: PIX_W] <= pix.pix_data;
                    if (last_pixel) begin
                        linha  <= '0;
                        coluna <= '0;
                    end else if (coluna == COL_W'(LARGURA - 1)) begin
                        coluna <= '0;
                        linha  <= linha + 1'b1;
                    end else begin
                        coluna <= coluna + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Self-checking bench for pixel_frame_loader: expected frames are queued as pixels are
// driven and compared when frame_valid rises; handshake, sof_error and reset checked inline.
module tb_pixel_frame_loader;
    import image_pkg::*;

    localparam int NPIX = LARGURA * ALTURA;

    logic clock;
    logic reset;

    pixel_frame_loader_if bus ();

    pixel_frame_loader dut (
        .clock (clock),
        .reset (reset),
        .pix   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int sof_err_count = 0;
    logic fv_prev = 1'b0;
    logic [FRAME_W-1:0] sb_q[$];
    logic [FRAME_W-1:0] exp_frame;
    logic [FRAME_W-1:0] held_frame;

    task automatic check(input string tag, input logic [FRAME_W-1:0] got, input logic [FRAME_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer and sof_error pulse counter, sampled away from the rising edge.
    always @(negedge clock) begin
        if (bus.sof_error === 1'b1) sof_err_count++;
        if (bus.frame_valid === 1'b1 && fv_prev === 1'b0) begin
            check("frame_expected", FRAME_W'(sb_q.size() > 0), FRAME_W'(1));
            if (sb_q.size() > 0) check("frame_data", bus.frame_out, sb_q.pop_front());
        end
        fv_prev = bus.frame_valid;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called just after a falling edge; returns just after the falling edge that follows acceptance.
    task automatic send_beat(input logic [7:0] d, input logic s);
        int n = 0;
        bus.pix_data  = d;
        bus.pix_sof   = s;
        bus.pix_valid = 1'b1;
        while (bus.pix_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) check("ready_timeout", FRAME_W'(bus.pix_ready), FRAME_W'(1));
        @(negedge clock);
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic do_ack();
        bus.frame_ack = 1'b1;
        @(negedge clock);
        bus.frame_ack = 1'b0;
    endtask

    task automatic gap(input int max_gap);
        repeat ($urandom_range(0, max_gap)) @(negedge clock);
    endtask

    initial begin
        logic [7:0] v;
        int ff_count;

        reset         = 1'b0;
        bus.pix_data  = '0;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.frame_ack = 1'b0;

        // 1. Reset
        repeat (3) @(negedge clock);
        check("rst_frame_out",   bus.frame_out,               FRAME_W'(0));
        check("rst_frame_valid", FRAME_W'(bus.frame_valid),   FRAME_W'(0));
        check("rst_sof_error",   FRAME_W'(bus.sof_error),     FRAME_W'(0));
        check("rst_pix_ready",   FRAME_W'(bus.pix_ready),     FRAME_W'(0));
        reset = 1'b1;
        #1;
        check("rel_pix_ready_0", FRAME_W'(bus.pix_ready),     FRAME_W'(0));
        @(negedge clock);
        check("rel_pix_ready_1", FRAME_W'(bus.pix_ready),     FRAME_W'(1));

        // 2. Ramp 0..63, continuous valid
        exp_frame = '0;
        for (int k = 0; k < NPIX; k++) exp_frame[k*8 +: 8] = 8'(k);
        sb_q.push_back(exp_frame);
        for (int k = 0; k < NPIX; k++) send_beat(8'(k), k == 0);
        check("ramp_frame_valid", FRAME_W'(bus.frame_valid), FRAME_W'(1));
        check("ramp_pix_ready",   FRAME_W'(bus.pix_ready),   FRAME_W'(0));
        check("ramp_down_byte0",
              FRAME_W'((10'(bus.frame_out[0*8 +: 8]) + 10'(bus.frame_out[1*8 +: 8]) +
                        10'(bus.frame_out[8*8 +: 8]) + 10'(bus.frame_out[9*8 +: 8])) >> 2),
              FRAME_W'(4));
        do_ack();

        // 3. Random gaps, then hold FULL with 0xAA offered
        exp_frame = '0;
        for (int k = 0; k < NPIX; k++) exp_frame[k*8 +: 8] = 8'((k * 7 + 3) & 8'hFF);
        sb_q.push_back(exp_frame);
        for (int k = 0; k < NPIX; k++) begin
            gap(3);
            send_beat(8'((k * 7 + 3) & 8'hFF), k == 0);
        end
        held_frame    = exp_frame;
        bus.pix_data  = 8'hAA;
        bus.pix_valid = 1'b1;
        repeat (10) @(negedge clock);
        check("full_pix_ready",   FRAME_W'(bus.pix_ready),   FRAME_W'(0));
        check("full_frame_hold",  bus.frame_out,             held_frame);
        bus.pix_valid = 1'b0;
        do_ack();
        check("ack_frame_valid",  FRAME_W'(bus.frame_valid), FRAME_W'(0));
        check("ack_pix_ready",    FRAME_W'(bus.pix_ready),   FRAME_W'(1));

        // 4. Non-sof beats in IDLE are dropped
        for (int k = 0; k < 5; k++) send_beat(8'hFF, 1'b0);
        exp_frame = '0;
        for (int k = 0; k < NPIX; k++) exp_frame[k*8 +: 8] = 8'(k);
        sb_q.push_back(exp_frame);
        for (int k = 0; k < NPIX; k++) send_beat(8'(k), k == 0);
        ff_count = 0;
        for (int k = 0; k < NPIX; k++) if (bus.frame_out[k*8 +: 8] == 8'hFF) ff_count++;
        check("idle_no_ff", FRAME_W'(ff_count), FRAME_W'(0));
        do_ack();

        // 5. sof re-asserted on pixel 20
        for (int k = 0; k < 20; k++) send_beat(8'(8'h10 + k), k == 0);
        exp_frame = '0;
        for (int k = 0; k < NPIX; k++) exp_frame[k*8 +: 8] = 8'(8'h80 + k);
        sb_q.push_back(exp_frame);
        for (int k = 0; k < NPIX - 1; k++) send_beat(8'(8'h80 + k), k == 0);
        check("restart_not_yet_valid", FRAME_W'(bus.frame_valid), FRAME_W'(0));
        send_beat(8'(8'h80 + NPIX - 1), 1'b0);
        check("restart_frame_valid", FRAME_W'(bus.frame_valid),  FRAME_W'(1));
        check("restart_byte0",       FRAME_W'(bus.frame_out[7:0]), FRAME_W'(8'h80));
        check("sof_error_pulses",    FRAME_W'(sof_err_count),    FRAME_W'(1));
        do_ack();

        // 6. Reset mid-frame
        for (int k = 0; k < 30; k++) send_beat(8'(8'h40 + k), k == 0);
        reset = 1'b0;
        #1;
        check("midrst_frame_out",   bus.frame_out,             FRAME_W'(0));
        check("midrst_frame_valid", FRAME_W'(bus.frame_valid), FRAME_W'(0));
        check("midrst_pix_ready",   FRAME_W'(bus.pix_ready),   FRAME_W'(0));
        check("midrst_sof_error",   FRAME_W'(bus.sof_error),   FRAME_W'(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            v = 8'(8'h55 + k);
            send_beat(v, 1'b0);
        end
        check("post_rst_dropped",   bus.frame_out,             FRAME_W'(0));
        check("post_rst_no_valid",  FRAME_W'(bus.frame_valid), FRAME_W'(0));
        check("post_rst_ready",     FRAME_W'(bus.pix_ready),   FRAME_W'(1));
        check("sb_drained",         FRAME_W'(sb_q.size()),     FRAME_W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
